// File: rtl/rr_reg_arbiter.sv
// Round-robin req/grant arbiter guarding one shared DATA_W-bit register.
// Optional HOLD_TIMEOUT_EN: force release after MAX_HOLD consecutive writes.
module rr_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_W-1:0]         wdata,
  output logic [NUM_REQ-1:0]                grant,
  output logic [$clog2(NUM_REQ)-1:0]        owner,
  output logic [DATA_W-1:0]                 q,
  output logic                              q_valid
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1) begin : g_bad_param
      $error("rr_reg_arbiter: NUM_REQ must be 2..16 and MAX_HOLD >= 1");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic [PW-1:0]       owner_reg, owner_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic [DATA_W-1:0]   q_reg, q_next;
  logic                q_valid_reg, q_valid_next;

  logic [DATA_W-1:0]   lane [NUM_REQ];
  logic [PW-1:0]       win;
  logic                found;
  logic [PW:0]         idx_wide;
  logic [PW-1:0]       owner_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // First requester at or after ptr, wrapping at NUM_REQ-1.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    idx_wide = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_wide = {1'b0, ptr_reg} + (PW+1)'(k);
      if (idx_wide >= NREQ_W) idx_wide = idx_wide - NREQ_W;
      if (!found && req[idx_wide[PW-1:0]]) begin
        found = 1'b1;
        win   = idx_wide[PW-1:0];
      end
    end
  end

  assign owner_inc = (owner_reg == LAST_IDX) ? '0 : owner_reg + PW'(1);

`ifdef HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_reg, hold_next, hold_inc;
  assign hold_inc = hold_reg + HW'(1);
`endif

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    q_next       = q_reg;
    q_valid_next = q_valid_reg;
`ifdef HOLD_TIMEOUT_EN
    hold_next    = hold_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next      = GRANT;
          grant_next      = '0;
          grant_next[win] = 1'b1;
          owner_next      = win;
`ifdef HOLD_TIMEOUT_EN
          hold_next       = '0;
`endif
        end
      end
      GRANT: begin
        if (req[owner_reg]) begin
          q_next       = lane[owner_reg];
          q_valid_next = 1'b1;
`ifdef HOLD_TIMEOUT_EN
          hold_next    = hold_inc;
          // The write that reaches the limit still lands; ownership ends with it.
          if (hold_inc == HW'(MAX_HOLD)) begin
            state_next = IDLE;
            grant_next = '0;
            owner_next = '0;
            ptr_next   = owner_inc;
          end
`endif
        end else begin
          state_next = IDLE;
          grant_next = '0;
          owner_next = '0;
          ptr_next   = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      owner_reg   <= '0;
      ptr_reg     <= '0;
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      q_reg       <= q_next;
      q_valid_reg <= q_valid_next;
`ifdef HOLD_TIMEOUT_EN
      hold_reg    <= hold_next;
`endif
    end
  end

  assign grant   = grant_reg;
  assign owner   = owner_reg;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter (NUM_REQ=4, DATA_W=8, MAX_HOLD=4).
module tb_rr_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_valid;

  int cmp_count = 0;
  int err_count = 0;
  int cyc = 0;

  rr_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .grant(grant), .owner(owner), .q(q), .q_valid(q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d req=%b grant=%b owner=%0d q=%h q_valid=%b",
             cyc, req, grant, owner, q, q_valid);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    req   = 4'b0000;
    wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; wdata = '0;
    #2;
    cmp_count++; if (grant !== 4'b0000) begin err_count++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    cmp_count++; if (owner !== 2'd0) begin err_count++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    cmp_count++; if (q !== 8'h00 || q_valid !== 1'b0) begin err_count++; $display("FAIL reset_q got=%h/%b exp=00/0", q, q_valid); end
    #3 rst_n = 1'b1;
    req = 4'b0001; wdata[7:0] = 8'h3C;
    tick();
    tick();
    cmp_count++; if (q !== 8'h3C || q_valid !== 1'b1) begin err_count++; $display("FAIL pre_reset_write got=%h/%b exp=3c/1", q, q_valid); end
    // Assert reset mid-cycle while owning; effect must appear without an edge.
    #3 rst_n = 1'b0;
    #1;
    cmp_count++; if (grant !== 4'b0000 || owner !== 2'd0) begin err_count++; $display("FAIL async_reset_grant got=%b/%0d exp=0000/0", grant, owner); end
    cmp_count++; if (q !== 8'h00 || q_valid !== 1'b0) begin err_count++; $display("FAIL async_reset_q got=%h/%b exp=00/0", q, q_valid); end
    #2 rst_n = 1'b1;
    req = 4'b0000;
    tick();
    cmp_count++; if (grant !== 4'b0000) begin err_count++; $display("FAIL post_reset_idle got=%b exp=0000", grant); end
  endtask

  task automatic test_single_writer();
    do_reset();
    req = 4'b0001; wdata[7:0] = 8'hA5;
    tick();
    cmp_count++; if (grant !== 4'b0001 || owner !== 2'd0) begin err_count++; $display("FAIL single_grant got=%b/%0d exp=0001/0", grant, owner); end
    cmp_count++; if (q_valid !== 1'b0) begin err_count++; $display("FAIL single_no_early_write got=%b exp=0", q_valid); end
    tick();
    cmp_count++; if (q !== 8'hA5 || q_valid !== 1'b1) begin err_count++; $display("FAIL single_write got=%h/%b exp=a5/1", q, q_valid); end
    tick();
    req = 4'b0000;
    tick();
    cmp_count++; if (grant !== 4'b0000 || q !== 8'hA5) begin err_count++; $display("FAIL single_release got=%b/%h exp=0000/a5", grant, q); end
    // ptr now 1: requester 1 beats requester 0.
    req = 4'b0011;
    tick();
    cmp_count++; if (grant !== 4'b0010 || owner !== 2'd1) begin err_count++; $display("FAIL single_ptr_adv got=%b/%0d exp=0010/1", grant, owner); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    do_reset();
    wdata = 32'h13121110;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      exp_q = 8'h10 + 8'(k);
      tick();
      cmp_count++; if (grant !== exp_g || owner !== 2'(k)) begin err_count++; $display("FAIL rr_grant%0d got=%b/%0d exp=%b/%0d", k, grant, owner, exp_g, k); end
      tick();
      cmp_count++; if (q !== exp_q) begin err_count++; $display("FAIL rr_q%0d got=%h exp=%h", k, q, exp_q); end
      req[k] = 1'b0;
      tick();
      cmp_count++; if (grant !== 4'b0000) begin err_count++; $display("FAIL rr_idle%0d got=%b exp=0000", k, grant); end
      req[k] = 1'b1;
    end
    tick();
    cmp_count++; if (grant !== 4'b0001) begin err_count++; $display("FAIL rr_wrap got=%b exp=0001", grant); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap_priority();
    do_reset();
    wdata = 32'hD3C2B1A0;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    cmp_count++; if (grant !== 4'b1000 || owner !== 2'd3) begin err_count++; $display("FAIL wrap_first got=%b/%0d exp=1000/3", grant, owner); end
    tick();
    cmp_count++; if (q !== 8'hD3) begin err_count++; $display("FAIL wrap_q got=%h exp=d3", q); end
    req = 4'b0001;
    tick();
    tick();
    cmp_count++; if (grant !== 4'b0001 || owner !== 2'd0) begin err_count++; $display("FAIL wrap_second got=%b/%0d exp=0001/0", grant, owner); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_early_drop();
    do_reset();
    wdata = 32'h00EE5500;
    req = 4'b0010;
    tick();
    wdata[23:16] = 8'hxx;
    tick();
    cmp_count++; if (q !== 8'h55) begin err_count++; $display("FAIL early_owner_q got=%h exp=55", q); end
    req = 4'b0110;
    tick();
    req = 4'b0010;
    cmp_count++; if (grant !== 4'b0010 || q !== 8'h55) begin err_count++; $display("FAIL early_ignored got=%b/%h exp=0010/55", grant, q); end
    req = 4'b0000;
    tick();
    tick();
    cmp_count++; if (grant !== 4'b0000 || q !== 8'h55) begin err_count++; $display("FAIL early_lost got=%b/%h exp=0000/55", grant, q); end
  endtask

  task automatic test_grant_drop();
    do_reset();
    wdata = 32'h44332211;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    cmp_count++; if (grant !== 4'b0000 || q_valid !== 1'b0 || q !== 8'h00) begin err_count++; $display("FAIL gdrop_nowrite got=%b/%b/%h exp=0000/0/00", grant, q_valid, q); end
    req = 4'b1111;
    tick();
    cmp_count++; if (grant !== 4'b0010) begin err_count++; $display("FAIL gdrop_ptr got=%b exp=0010", grant); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    wdata = 32'h0000B1A0;
    req = 4'b0011;
    tick();
    cmp_count++; if (grant !== 4'b0001) begin err_count++; $display("FAIL hold_grant0 got=%b exp=0001", grant); end
`ifdef HOLD_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      tick();
      cmp_count++; if (grant !== ((k < 4) ? 4'b0001 : 4'b0000) || q !== 8'hA0) begin err_count++; $display("FAIL hold_w0_%0d got=%b/%h exp=%b/a0", k, grant, q, (k < 4) ? 4'b0001 : 4'b0000); end
    end
    tick();
    cmp_count++; if (grant !== 4'b0010) begin err_count++; $display("FAIL hold_move got=%b exp=0010", grant); end
    for (int k = 1; k <= 4; k++) tick();
    cmp_count++; if (grant !== 4'b0000 || q !== 8'hB1) begin err_count++; $display("FAIL hold_w1 got=%b/%h exp=0000/b1", grant, q); end
    tick();
    cmp_count++; if (grant !== 4'b0001) begin err_count++; $display("FAIL hold_back got=%b exp=0001", grant); end
`else
    for (int k = 1; k <= 55; k++) begin
      tick();
      cmp_count++; if (grant !== 4'b0001 || q !== 8'hA0) begin err_count++; $display("FAIL hold_keep%0d got=%b/%h exp=0001/a0", k, grant, q); end
    end
`endif
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_writer();
    test_round_robin();
    test_wrap_priority();
    test_early_drop();
    test_grant_drop();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
